// File: rtl/complex_nco_pkg.sv
// Shared types and the quarter-wave sine table generator for complex_phasor_nco.
// Table entries sample the first quadrant at half-index offsets, so the four quadrants mirror it exactly.
package complex_nco_pkg;

  typedef enum logic [1:0] {
    SM_INIT,
    SM_LOOKUP,
    SM_MAP,
    SM_SEND_OUTPUT
  } state_t;

  typedef logic [1:0] quadrant_t;

  localparam real HALF_PI = 1.5707963267948966;

  // q[k] = round(A * sin((pi/2) * (k + 0.5) / N)), evaluated at elaboration.
  function automatic int quarter_sine_value(input int k, input int addr_width, input int dout_width);
    real amp;
    real arg;
    amp = real'((1 << (dout_width - 1)) - 1);
    arg = HALF_PI * (real'(k) + 0.5) / real'(1 << addr_width);
    return $rtoi(amp * $sin(arg) + 0.5);
  endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine ROM with two independent registered read ports.
// One cycle read latency; reads happen only while rd_en is high, otherwise outputs hold.
module quarter_sine_rom
  import complex_nco_pkg::*;
#(
  parameter int G_LUT_ADDR_WIDTH = 10,
  parameter int G_DOUT_DWIDTH    = 16
) (
  input  logic                        clk,
  input  logic                        rd_en,
  input  logic [G_LUT_ADDR_WIDTH-1:0] addr_a,
  input  logic [G_LUT_ADDR_WIDTH-1:0] addr_b,
  output logic [G_DOUT_DWIDTH-1:0]    q_a,
  output logic [G_DOUT_DWIDTH-1:0]    q_b
);

  localparam int N = 1 << G_LUT_ADDR_WIDTH;

  logic [G_DOUT_DWIDTH-1:0] rom [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam int VAL = quarter_sine_value(i, G_LUT_ADDR_WIDTH, G_DOUT_DWIDTH);
    assign rom[i] = VAL[G_DOUT_DWIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      q_a <= rom[addr_a];
      q_b <= rom[addr_b];
    end
  end

endmodule

// File: rtl/complex_phasor_nco.sv
// Complex unit-phasor NCO (cos + j*sin) on a valid/ready stream; COMPLEX_NCO_PHASE_OFFSET_EN adds a lookup phase offset port.
// First valid 3 edges after reset release, then one sample per 3 cycles; outputs hold stable while dout_ready is low.
module complex_phasor_nco
  import complex_nco_pkg::*;
#(
  parameter int G_PHASE_WIDTH    = 32,
  parameter int G_LUT_ADDR_WIDTH = 10,
  parameter int G_DOUT_DWIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [G_PHASE_WIDTH-1:0] phase_inc,
`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
  input  logic [G_PHASE_WIDTH-1:0] phase_offset,
`endif
  output logic [G_DOUT_DWIDTH-1:0] dout_re,
  output logic [G_DOUT_DWIDTH-1:0] dout_im,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int PW = G_PHASE_WIDTH;
  localparam int AW = G_LUT_ADDR_WIDTH;
  localparam int DW = G_DOUT_DWIDTH;

  state_t            state;
  quadrant_t         quad_r;
  logic [PW-1:0]     phase_acc;
  logic [PW-1:0]     lookup_phase;
  logic [AW-1:0]     lut_idx;
  logic [DW-1:0]     q_k;
  logic [DW-1:0]     q_nk;
  logic [DW-1:0]     neg_k;
  logic [DW-1:0]     neg_nk;

`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
  assign lookup_phase = phase_acc + phase_offset;
`else
  assign lookup_phase = phase_acc;
`endif

  assign lut_idx = lookup_phase[PW-3 -: AW];

  // Phase bits below the table index are truncated; there is no interpolation.
  if (PW - 2 > AW) begin : g_trunc
    logic unused_low_phase;
    assign unused_low_phase = ^lookup_phase[PW-3-AW:0];
  end

  // N-1-k is the bitwise complement of an AW-bit index.
  quarter_sine_rom #(
    .G_LUT_ADDR_WIDTH(AW),
    .G_DOUT_DWIDTH   (DW)
  ) u_rom (
    .clk   (clk),
    .rd_en (state == SM_LOOKUP),
    .addr_a(lut_idx),
    .addr_b(~lut_idx),
    .q_a   (q_k),
    .q_b   (q_nk)
  );

  assign neg_k  = -q_k;
  assign neg_nk = -q_nk;

  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      state      <= SM_INIT;
      phase_acc  <= '0;
      quad_r     <= '0;
      dout_valid <= 1'b0;
      dout_re    <= '0;
      dout_im    <= '0;
    end else begin
      case (state)
        SM_INIT: begin
          state <= SM_LOOKUP;
        end
        SM_LOOKUP: begin
          quad_r <= lookup_phase[PW-1:PW-2];
          state  <= SM_MAP;
        end
        SM_MAP: begin
          case (quad_r)
            2'd0: begin dout_re <= q_nk;   dout_im <= q_k;    end
            2'd1: begin dout_re <= neg_k;  dout_im <= q_nk;   end
            2'd2: begin dout_re <= neg_nk; dout_im <= neg_k;  end
            2'd3: begin dout_re <= q_k;    dout_im <= neg_nk; end
          endcase
          dout_valid <= 1'b1;
          state      <= SM_SEND_OUTPUT;
        end
        SM_SEND_OUTPUT: begin
          if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            phase_acc  <= phase_acc + phase_inc;
            state      <= SM_LOOKUP;
          end
        end
        default: begin
          state <= SM_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_phasor_nco.sv
// Directed-vector bench for complex_phasor_nco; offset vector only with COMPLEX_NCO_PHASE_OFFSET_EN.
module tb_complex_phasor_nco;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] phase_inc;
`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
  logic [31:0] phase_offset;
`endif
  logic [15:0] dout_re;
  logic [15:0] dout_im;
  logic        dout_valid;
  logic        dout_ready;

  int vectors = 0;
  int errors  = 0;

  complex_phasor_nco dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .phase_inc   (phase_inc),
`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
    .phase_offset(phase_offset),
`endif
    .dout_re     (dout_re),
    .dout_im     (dout_im),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input int exp_re, input int exp_im);
    chk({tag, ".valid"}, {31'd0, dout_valid}, 1);
    chk({tag, ".re"}, $signed(dout_re), exp_re);
    chk({tag, ".im"}, $signed(dout_im), exp_im);
  endtask

  // Steps until dout_valid is seen, bounded; returns the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dout_valid && n < 20);
  endtask

  int n;

  initial begin
    reset      = 1'b0;
    enable     = 1'b1;
    phase_inc  = 32'h0;
    dout_ready = 1'b1;
`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
    phase_offset = 32'h0;
`endif
    repeat (3) step();
    chk("rst.valid", {31'd0, dout_valid}, 0);
    chk("rst.re", $signed(dout_re), 0);
    chk("rst.im", $signed(dout_im), 0);

    // Stationary phasor at phase 0
    reset = 1'b1;
    wait_valid(n);
    chk("first.latency", n, 3);
    chk_sample("first", 32767, 25);
    for (int i = 0; i < 2; i++) begin
      wait_valid(n);
      chk("still.latency", n, 3);
      chk_sample("still", 32767, 25);
    end

    // Forward quarter-turn rotation including accumulator wrap
    phase_inc = 32'h4000_0000;
    wait_valid(n); chk("fwd.latency", n, 3); chk_sample("fwd1", -25, 32767);
    wait_valid(n); chk_sample("fwd2", -32767, -25);
    wait_valid(n); chk_sample("fwd3", 25, -32767);
    wait_valid(n); chk_sample("fwd4", 32767, 25);

    // Reverse rotation
    phase_inc = 32'hC000_0000;
    wait_valid(n); chk_sample("rev1", 25, -32767);
    wait_valid(n); chk_sample("rev2", -32767, -25);
    wait_valid(n); chk_sample("rev3", -25, 32767);
    wait_valid(n); chk_sample("rev4", 32767, 25);

    // Stall with phase_inc toggling; only the handshake-edge value counts
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      phase_inc = (i % 2 == 0) ? 32'h4000_0000 : 32'h8000_0000;
      step();
      chk_sample("stall", 32767, 25);
    end
    phase_inc  = 32'hC000_0000;
    dout_ready = 1'b1;
    wait_valid(n);
    chk("stall.latency", n, 3);
    chk_sample("after_stall", 25, -32767);

    // Fine index: acc = 0xC0000000 + 0x40400000 -> quadrant 0, k = 4
    phase_inc = 32'h4040_0000;
    wait_valid(n);
    chk_sample("k4", 32766, 226);

    // Reset pulse while in SM_MAP drops the sample and clears the accumulator
    phase_inc = 32'h0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rstmap.valid", {31'd0, dout_valid}, 0);
    chk("rstmap.re", $signed(dout_re), 0);
    reset = 1'b1;
    wait_valid(n);
    chk("rstmap.latency", n, 3);
    chk_sample("rstmap", 32767, 25);

    // Same via enable
    phase_inc = 32'h8000_0000;
    step();
    step();
    enable = 1'b0;
    step();
    chk("enmap.valid", {31'd0, dout_valid}, 0);
    enable    = 1'b1;
    phase_inc = 32'h0;
    wait_valid(n);
    chk("enmap.latency", n, 3);
    chk_sample("enmap", 32767, 25);

`ifdef COMPLEX_NCO_PHASE_OFFSET_EN
    reset        = 1'b0;
    phase_offset = 32'h8000_0000;
    step();
    reset = 1'b1;
    wait_valid(n);
    chk("offset.latency", n, 3);
    chk_sample("offset", -32767, -25);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
